// File: rtl/ec_share_arbiter.sv
// ec_share_arbiter: round-robin front end that shares one ErrorCorrection
// engine among N_REQ requesters, with a bounded wait for the engine result.
module ec_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*32-1:0] req_cw,
  input  logic [N_REQ*16-1:0] req_rem,
  output logic [N_REQ-1:0]   gnt,
  output logic               ec_start,
  output logic [31:0]        ec_cw,
  output logic [15:0]        ec_rem,
  input  logic               ec_dvalid,
  input  logic               ec_status,
  input  logic [15:0]        ec_dout,
  output logic               ec_abort,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [15:0]        rsp_data,
  output logic               rsp_status,
  output logic               rsp_tout,
  output logic               busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [TW-1:0]   r_timer;
  logic [31:0]     r_cw;
  logic [15:0]     r_rem;
  logic [15:0]     r_rsp_data;
  logic            r_rsp_status;
  logic            r_rsp_tout;

  logic [PW-1:0]   w_win;
  logic            w_found;
  logic            w_tmo;
  logic [31:0]     w_cw_arr  [N_REQ];
  logic [15:0]     w_rem_arr [N_REQ];

  // Unpack the flat codeword/remainder buses and decode one-hot outputs per requester
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_cw_arr[gi]  = req_cw[32*gi +: 32];
      assign w_rem_arr[gi] = req_rem[16*gi +: 16];
      assign gnt[gi]       = (r_state == S_ISSUE) && (r_owner == PW'(gi));
      assign rsp_valid[gi] = (r_state == S_RESP)  && (r_owner == PW'(gi));
    end
  endgenerate

  assign ec_start   = (r_state == S_ISSUE);
  assign ec_cw      = r_cw;
  assign ec_rem     = r_rem;
  assign ec_abort   = (r_state == S_RESP) && r_rsp_tout;
  assign rsp_data   = r_rsp_data;
  assign rsp_status = r_rsp_status;
  assign rsp_tout   = r_rsp_tout;
  assign busy       = (r_state != S_IDLE);
  assign w_tmo      = (r_timer == TMAX);

  // Round-robin search: first set req bit starting just after the last owner
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(r_ptr) + k) % N_REQ;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; engine result beats a same-cycle timeout
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (ec_dvalid || w_tmo) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: capture winner, run the wait timer, latch the response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= PW'(N_REQ - 1);
      r_owner      <= '0;
      r_timer      <= '0;
      r_cw         <= '0;
      r_rem        <= '0;
      r_rsp_data   <= '0;
      r_rsp_status <= 1'b0;
      r_rsp_tout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner <= w_win;
            r_cw    <= w_cw_arr[w_win];
            r_rem   <= w_rem_arr[w_win];
          end
        end
        S_ISSUE: r_timer <= '0;
        S_WAIT: begin
          if (ec_dvalid) begin
            r_rsp_data   <= ec_dout;
            r_rsp_status <= ec_status;
            r_rsp_tout   <= 1'b0;
          end else if (w_tmo) begin
            r_rsp_data   <= '0;
            r_rsp_status <= 1'b1;
            r_rsp_tout   <= 1'b1;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RESP: r_ptr <= r_owner;
        default: ;
      endcase
    end
  end

endmodule
